// File: rtl/misc_arb_pkg.sv
// Shared constants for the misc-unit arbiter: op encodings, payload/result field
// offsets and width helpers for the packed lane payload and unit result.
package misc_arb_pkg;

    typedef enum logic [4:0] {
        OP_MOV_ACC  = 5'd0,
        OP_ABS      = 5'd1,
        OP_CLAMP    = 5'd2,
        OP_LSH      = 5'd3,
        OP_RSH      = 5'd4,
        OP_MOV_UACC = 5'd5,
        OP_MOV_LACC = 5'd6
    } misc_op_e;

    // Payload, LSB first: commit_flag, commit_id[8:0], dest[3:0], shift[4:0],
    // saturate_disable, operation[4:0], accumulator[2*DW], arg_c, arg_b, arg_a, block.
    localparam int unsigned PL_COMMIT_FLAG = 0;
    localparam int unsigned PL_COMMIT_ID   = 1;
    localparam int unsigned PL_DEST        = 10;
    localparam int unsigned PL_SHIFT       = 14;
    localparam int unsigned PL_SAT_DIS     = 19;
    localparam int unsigned PL_OP          = 20;
    localparam int unsigned PL_ACC         = 25;

    // Result, LSB first: commit_flag, commit_id[8:0], result[2*DW], dest[3:0], block.
    localparam int unsigned RS_COMMIT_FLAG = 0;
    localparam int unsigned RS_COMMIT_ID   = 1;
    localparam int unsigned RS_RESULT      = 10;

    function automatic int unsigned bw_of(input int unsigned n_blocks);
        return (n_blocks > 1) ? $clog2(n_blocks) : 1;
    endfunction

    function automatic int unsigned pw_of(input int unsigned bw, input int unsigned dw);
        return bw + 5 * dw + 25;
    endfunction

    function automatic int unsigned rw_of(input int unsigned bw, input int unsigned dw);
        return bw + 2 * dw + 14;
    endfunction

    function automatic int unsigned pl_arg_c(input int unsigned dw);
        return PL_ACC + 2 * dw;
    endfunction

    function automatic int unsigned pl_arg_b(input int unsigned dw);
        return PL_ACC + 3 * dw;
    endfunction

    function automatic int unsigned pl_arg_a(input int unsigned dw);
        return PL_ACC + 4 * dw;
    endfunction

    function automatic int unsigned pl_block(input int unsigned dw);
        return PL_ACC + 5 * dw;
    endfunction

    function automatic int unsigned rs_dest(input int unsigned dw);
        return RS_RESULT + 2 * dw;
    endfunction

    function automatic int unsigned rs_block(input int unsigned dw);
        return RS_RESULT + 2 * dw + 4;
    endfunction

    localparam int unsigned PW = pw_of(bw_of(256), 16);
    localparam int unsigned RW = rw_of(bw_of(256), 16);

endpackage

// File: rtl/misc_tag_fifo.sv
// In-order tag FIFO: circular buffer with head/tail pointers wrapping at DEPTH.
// Caller guarantees no push when full unless it pops in the same cycle.
module misc_tag_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/misc_arbiter.sv
// Round-robin arbiter sharing one misc unit among N_REQ lanes; results return in order
// via a tag FIFO. Optional commit-sequence grant lock under `MISC_ARB_LOCK_EN.
module misc_arbiter
    import misc_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned N_BLOCKS     = 256,
    parameter int unsigned MAX_INFLIGHT = 2,
    localparam int unsigned GW = $clog2(N_REQ),
    localparam int unsigned PW_L = pw_of(bw_of(N_BLOCKS), DATA_WIDTH),
    localparam int unsigned RW_L = rw_of(bw_of(N_BLOCKS), DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*PW_L-1:0] req_payload,
    output logic                  unit_in_valid,
    input  logic                  unit_in_ready,
    output logic [PW_L-1:0]       unit_payload,
    input  logic                  unit_out_valid,
    output logic                  unit_out_ready,
    input  logic [RW_L-1:0]       unit_result,
    output logic [N_REQ-1:0]      res_valid,
    input  logic [N_REQ-1:0]      res_ready,
    output logic [RW_L-1:0]       res_payload,
    output logic [GW-1:0]         grant_idx,
    output logic                  tag_error
);

    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] rr_grant;
    logic [GW-1:0] grant;
    logic [GW-1:0] scan;
    logic [GW-1:0] head;
    logic          found;
    logic          any_req;
    logic          advance;
    logic          full;
    logic          empty;
    logic          can_push;
    logic          take_in;
    logic          pop;

    always_comb begin
        rr_grant = rr_ptr;
        found    = 1'b0;
        scan     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            scan = GW'((i + 32'(rr_ptr)) % N_REQ);
            if (!found && req_valid[scan]) begin
                rr_grant = scan;
                found    = 1'b1;
            end
        end
    end

`ifdef MISC_ARB_LOCK_EN
    logic          locked;
    logic [GW-1:0] lock_lane;
    logic          lock_hold;

    // Lock drops the same cycle the locked lane withdraws its request.
    assign lock_hold = locked & req_valid[lock_lane];
    assign any_req   = lock_hold | (|req_valid);
    assign grant     = lock_hold ? lock_lane : rr_grant;
    assign advance   = take_in & unit_payload[PL_COMMIT_FLAG];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            locked    <= 1'b0;
            lock_lane <= '0;
        end else if (enable) begin
            if (take_in) begin
                locked    <= ~unit_payload[PL_COMMIT_FLAG];
                lock_lane <= grant;
            end else if (!lock_hold) begin
                locked <= 1'b0;
            end
        end
    end
`else
    assign any_req = |req_valid;
    assign grant   = rr_grant;
    assign advance = take_in;
`endif

    assign unit_payload   = req_payload[32'(grant) * PW_L +: PW_L];
    assign unit_out_ready = enable & ~empty & res_ready[head];
    assign pop            = unit_out_valid & unit_out_ready;
    assign can_push       = enable & (~full | pop);
    assign unit_in_valid  = any_req & can_push;
    assign take_in        = unit_in_valid & unit_in_ready;
    assign res_payload    = unit_result;
    assign grant_idx      = grant;

    always_comb begin
        req_ready        = '0;
        req_ready[grant] = unit_in_ready & can_push;
        res_valid        = '0;
        res_valid[head]  = unit_out_valid & enable & ~empty;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr    <= '0;
            tag_error <= 1'b0;
        end else begin
            if (advance) rr_ptr <= (grant == GW'(N_REQ - 1)) ? '0 : grant + 1'b1;
            if (enable && unit_out_valid && empty) tag_error <= 1'b1;
        end
    end

    misc_tag_fifo #(
        .DEPTH(MAX_INFLIGHT),
        .WIDTH(GW)
    ) u_tags (
        .clk  (clk),
        .reset(reset),
        .push (take_in),
        .pop  (pop),
        .din  (grant),
        .head (head),
        .full (full),
        .empty(empty)
    );

endmodule
